// File: rtl/numa_frame_parser.sv
// numa_frame_parser: sync/length/payload/XOR-checksum byte-stream frame parser with held valid/ready output
module numa_frame_parser #(
  parameter int          NUM_FIELDS     = 3,
  parameter int          FIELD_BYTES    = 4,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [7:0]                            data_in,
  input  logic                                  data_valid,
  output logic [NUM_FIELDS*FIELD_BYTES*8-1:0]   out_fields,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [7:0]                            chk_err_cnt,
  output logic [7:0]                            len_err_cnt,
  output logic [7:0]                            tmo_err_cnt,
  output logic [7:0]                            ovr_err_cnt
);
  localparam int PLEN = NUM_FIELDS * FIELD_BYTES;
  localparam int IW   = $clog2(PLEN + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHECK} state_t;
  state_t state, state_d;
  logic [IW-1:0] idx;
  logic [7:0] xr;
  logic [TW-1:0] idle;
  logic [7:0] sh [PLEN];
  logic [PLEN*8-1:0] flat;
  logic tmo, len_err, chk_err, ovr, ld;
  function automatic logic [7:0] sat(input logic [7:0] c, input logic e);
    return (e && c != 8'hFF) ? c + 8'd1 : c;
  endfunction
  // a byte arriving on the would-be timeout cycle suppresses the timeout
  always_comb begin
    state_d = state;
    len_err = 1'b0;
    chk_err = 1'b0;
    ovr     = 1'b0;
    ld      = 1'b0;
    tmo     = state != HUNT && !data_valid && idle == TW'(TIMEOUT_CYCLES - 1);
    if (tmo) state_d = HUNT;
    else if (data_valid)
      case (state)
        HUNT:    state_d = data_in == SYNC_BYTE ? LEN : HUNT;
        LEN: begin
          len_err = data_in != 8'(PLEN);
          state_d = len_err ? HUNT : PAYLOAD;
        end
        PAYLOAD: state_d = idx == IW'(PLEN - 1) ? CHECK : PAYLOAD;
        default: begin
          state_d = HUNT;
          chk_err = data_in != xr;
          ld      = !chk_err && (!out_valid || out_ready);
          ovr     = !chk_err && out_valid && !out_ready;
        end
      endcase
  end
  // shadow bytes land in arrival order; the first byte of each field becomes its MSB
  always_comb begin
    flat = '0;
    for (int k = 0; k < PLEN; k++)
      flat[((k / FIELD_BYTES) * FIELD_BYTES + FIELD_BYTES - 1 - k % FIELD_BYTES) * 8 +: 8] = sh[k];
  end
  always_ff @(posedge clk)
    if (state == PAYLOAD && data_valid) sh[idx] <= data_in;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= HUNT;
      idx         <= '0;
      xr          <= '0;
      idle        <= '0;
      out_fields  <= '0;
      out_valid   <= 1'b0;
      chk_err_cnt <= '0;
      len_err_cnt <= '0;
      tmo_err_cnt <= '0;
      ovr_err_cnt <= '0;
    end else begin
      state       <= state_d;
      idle        <= (data_valid || state_d == HUNT) ? '0 : idle + TW'(1);
      idx         <= (state == LEN && data_valid) ? '0 : (state == PAYLOAD && data_valid) ? idx + IW'(1) : idx;
      xr          <= (state == LEN && data_valid) ? data_in : (state == PAYLOAD && data_valid) ? xr ^ data_in : xr;
      out_fields  <= ld ? flat : out_fields;
      out_valid   <= ld ? 1'b1 : (out_valid && out_ready) ? 1'b0 : out_valid;
      chk_err_cnt <= sat(chk_err_cnt, chk_err);
      len_err_cnt <= sat(len_err_cnt, len_err);
      tmo_err_cnt <= sat(tmo_err_cnt, tmo);
      ovr_err_cnt <= sat(ovr_err_cnt, ovr);
    end
endmodule

// File: tb/tb_numa_frame_parser.sv
// tb_numa_frame_parser: directed and randomized checks of numa_frame_parser against a byte-queue reference model
module tb_numa_frame_parser;
  localparam int NF = 3, FB = 4, PLEN = NF * FB, FW = FB * 8, T = 1024;
  logic clk = 1'b0, rst_n = 1'b0, data_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic [NF*FW-1:0] out_fields;
  logic out_valid;
  logic [7:0] chk_err_cnt, len_err_cnt, tmo_err_cnt, ovr_err_cnt;
  numa_frame_parser #(.NUM_FIELDS(NF), .FIELD_BYTES(FB), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_valid(data_valid),
    .out_fields(out_fields), .out_valid(out_valid), .out_ready(out_ready),
    .chk_err_cnt(chk_err_cnt), .len_err_cnt(len_err_cnt),
    .tmo_err_cnt(tmo_err_cnt), .ovr_err_cnt(ovr_err_cnt));
  always #5 clk = ~clk;
  // reference model: bytes collected since the sync byte, plus idle-cycle count
  bit in_frame;
  int idle;
  logic [7:0] fr[$];
  logic [NF*FW-1:0] m_fields;
  logic m_valid;
  logic [7:0] m_chk, m_len, m_tmo, m_ovr;
  logic [7:0] pl [PLEN];
  bit rand_rdy;
  int n_pass, n_tot;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic logic [7:0] inc(input logic [7:0] c);
    return c == 8'hFF ? c : c + 8'd1;
  endfunction
  task automatic model_reset();
    in_frame = 0; idle = 0; fr.delete();
    m_fields = '0; m_valid = 0;
    m_chk = 0; m_len = 0; m_tmo = 0; m_ovr = 0;
  endtask
  task automatic step(input logic dv, input logic [7:0] b, input logic rdy);
    logic load = 0;
    logic [7:0] x;
    logic [FW-1:0] v;
    if (dv) begin
      idle = 0;
      if (!in_frame) begin
        in_frame = (b == 8'hA5);
        fr.delete();
      end else begin
        fr.push_back(b);
        if (fr.size() == 1 && b != 8'(PLEN)) begin
          m_len = inc(m_len); in_frame = 0;
        end else if (fr.size() == PLEN + 2) begin
          in_frame = 0;
          x = 0;
          for (int i = 0; i <= PLEN; i++) x ^= fr[i];
          if (b != x) m_chk = inc(m_chk);
          else if (m_valid && !rdy) m_ovr = inc(m_ovr);
          else begin
            load = 1;
            for (int f = 0; f < NF; f++) begin
              v = 0;
              for (int j = 0; j < FB; j++) v = (v << 8) | FW'(fr[1 + f * FB + j]);
              m_fields[f*FW +: FW] = v;
            end
          end
        end
      end
    end else if (in_frame) begin
      idle++;
      if (idle == T) begin
        m_tmo = inc(m_tmo); in_frame = 0; idle = 0;
      end
    end
    if (load) m_valid = 1;
    else if (m_valid && rdy) m_valid = 0;
  endtask
  task automatic check_all();
    check("valid", out_valid, m_valid);
    check("fields", out_fields, m_fields);
    check("errs", {chk_err_cnt, len_err_cnt, tmo_err_cnt, ovr_err_cnt}, {m_chk, m_len, m_tmo, m_ovr});
  endtask
  task automatic cyc(input logic dv, input logic [7:0] b);
    logic r;
    if (rand_rdy) out_ready = ($urandom_range(0, 2) != 0);
    data_valid = dv; data_in = b; r = out_ready;
    @(posedge clk);
    step(dv, b, r);
    #1 check_all();
  endtask
  task automatic idle_n(input int n);
    repeat (n) cyc(0, 8'h00);
  endtask
  task automatic send_frame(input logic [7:0] lenb, input logic [7:0] flip, input int gap);
    logic [7:0] x;
    x = lenb;
    idle_n($urandom_range(0, gap)); cyc(1, 8'hA5);
    idle_n($urandom_range(0, gap)); cyc(1, lenb);
    for (int i = 0; i < PLEN; i++) begin
      x ^= pl[i];
      idle_n($urandom_range(0, gap)); cyc(1, pl[i]);
    end
    idle_n($urandom_range(0, gap)); cyc(1, x ^ flip);
  endtask
  task automatic std_payload();
    for (int i = 0; i < PLEN; i++) pl[i] = 8'((i + 1) * 17);
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    rst_n = 1;
    std_payload();
    out_ready = 1;
    send_frame(8'h0C, 8'h00, 0);
    check("good_valid", out_valid, 1'b1);
    check("good_fields", out_fields, 96'h99AABBCC_55667788_11223344);
    cyc(0, 8'h00);
    check("good_pulse", out_valid, 1'b0);
    send_frame(8'h0C, 8'h01, 0);
    check("bad_chk_cnt", chk_err_cnt, 8'd1);
    check("bad_chk_valid", out_valid, 1'b0);
    send_frame(8'h0C, 8'h00, 0);
    check("redo_fields", out_fields, 96'h99AABBCC_55667788_11223344);
    cyc(1, 8'hA5); cyc(1, 8'h0B); idle_n(2);
    check("len_cnt", len_err_cnt, 8'd1);
    cyc(1, 8'h00); cyc(1, 8'hFF); cyc(1, 8'h12);
    send_frame(8'h0C, 8'h00, 0);
    check("garbage_ok", out_valid, 1'b1);
    check("garbage_cnts", {chk_err_cnt, len_err_cnt, tmo_err_cnt, ovr_err_cnt}, 32'h01010000);
    cyc(0, 8'h00);
    out_ready = 0;
    send_frame(8'h0C, 8'h00, 0);
    for (int i = 0; i < PLEN; i++) pl[i] = 8'(i);
    send_frame(8'h0C, 8'h00, 0);
    check("ovr_cnt", ovr_err_cnt, 8'd1);
    check("ovr_held", out_fields, 96'h99AABBCC_55667788_11223344);
    out_ready = 1;
    cyc(0, 8'h00);
    check("ovr_drain", out_valid, 1'b0);
    std_payload();
    cyc(1, 8'hA5); cyc(1, 8'h0C); cyc(1, 8'h11);
    idle_n(T);
    check("tmo_cnt", tmo_err_cnt, 8'd1);
    send_frame(8'h0C, 8'h00, 0);
    check("after_tmo", out_valid, 1'b1);
    cyc(1, 8'hA5); cyc(1, 8'h0C); cyc(1, pl[0]);
    idle_n(T - 1);
    for (int i = 1; i < PLEN; i++) cyc(1, pl[i]);
    cyc(1, 8'hC0);
    check("edge_no_tmo", tmo_err_cnt, 8'd1);
    check("edge_valid", out_valid, 1'b1);
    cyc(1, 8'hA5); cyc(1, 8'h0C); cyc(1, 8'h11); cyc(1, 8'h22);
    rst_n = 0;
    #2 model_reset();
    check_all();
    check("rst_fields", out_fields, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    send_frame(8'h0C, 8'h00, 0);
    check("post_rst", out_fields, 96'h99AABBCC_55667788_11223344);
    repeat (300) send_frame(8'h0C, 8'h5A, 0);
    check("chk_sat", chk_err_cnt, 8'hFF);
    rand_rdy = 1;
    for (int n = 0; n < 200; n++) begin
      int mode;
      mode = $urandom_range(0, 7);
      for (int i = 0; i < PLEN; i++) pl[i] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc(1, 8'($urandom_range(0, 8'hA4)));
      if (mode == 0) send_frame(8'h0C, 8'($urandom_range(1, 255)), 2);
      else if (mode == 1) send_frame(8'($urandom_range(13, 255)), 8'h00, 1);
      else if (mode == 2) begin
        cyc(1, 8'hA5); cyc(1, 8'h0C); cyc(1, pl[0]);
        idle_n($urandom_range(0, 1) != 0 ? T : T - 1);
        cyc(1, 8'h00);
      end else send_frame(8'h0C, 8'h00, mode == 3 ? 3 : 0);
    end
    rand_rdy = 0;
    out_ready = 1;
    idle_n(4);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
